// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - datapath-facing bundle of the multicycle MIPS controller
interface mips_multicycle_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ready;
  logic             pc_ld;
  logic             ir_w;
  logic             reg_rd;
  logic             reg_wr;
  logic             mem_rd;
  logic             mem_wd;
  logic             sel_dir;
  logic             sel_dest;
  logic             sel_dat;
  logic             sel_operB;
  logic [1:0]       sel_pc;
  logic [2:0]       sel_operA;
  logic [2:0]       alu_fun;
  logic [2:0]       state;
  logic             err;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_ld, ir_w, reg_rd, reg_wr, mem_rd, mem_wd,
    output sel_dir, sel_dest, sel_dat, sel_operB, sel_pc, sel_operA, alu_fun,
    output state, err, instr_count
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_ld, ir_w, reg_rd, reg_wr, mem_rd, mem_wd,
    input  sel_dir, sel_dest, sel_dat, sel_operB, sel_pc, sel_operA, alu_fun,
    input  state, err, instr_count
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - opcode-driven multicycle MIPS control unit with wait-state timeout
module mips_multicycle_ctrl #(
  parameter int WAIT_W  = 4,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  mips_multicycle_ctrl_if.master  bus
);
  typedef enum logic [2:0] {
    FETCH = 3'd0,
    DECO  = 3'd1,
    EXE   = 3'd2,
    MEM   = 3'd3,
    WB    = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t            st, st_nx;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  cnt;
  logic              err_q;

  logic       is_r, is_lw, is_sw, is_beq, is_j, is_addi;
  logic       funct_ok, op_ok, timed_out, retire;
  logic [2:0] alu_r;

  logic pc_ld_c, ir_w_c, reg_rd_c, reg_wr_c, mem_rd_c, mem_wd_c;
  logic sel_dir_c, sel_dest_c, sel_dat_c, sel_operB_c;
  logic [1:0] sel_pc_c;
  logic [2:0] sel_operA_c, alu_fun_c;

  assign is_r    = (bus.opcode == OP_R);
  assign is_lw   = (bus.opcode == OP_LW);
  assign is_sw   = (bus.opcode == OP_SW);
  assign is_beq  = (bus.opcode == OP_BEQ);
  assign is_j    = (bus.opcode == OP_J);
  assign is_addi = (bus.opcode == OP_ADDI);

  always_comb begin
    alu_r    = ALU_ADD;
    funct_ok = 1'b1;
    case (bus.funct)
      6'h20:   alu_r = ALU_ADD;
      6'h22:   alu_r = ALU_SUB;
      6'h24:   alu_r = ALU_AND;
      6'h25:   alu_r = ALU_OR;
      6'h2A:   alu_r = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

  assign op_ok     = (is_r && funct_ok) || is_lw || is_sw || is_beq || is_j || is_addi;
  assign timed_out = (wait_cnt == WAIT_W'(TIMEOUT));
  // Any instruction completing returns to FETCH; ERR never does, so it is excluded.
  assign retire    = (st_nx == FETCH) && (st != FETCH) && (st != ERR);

  always_comb begin
    st_nx = st;
    case (st)
      FETCH: begin
        if (bus.mem_ready)   st_nx = DECO;
        else if (timed_out)  st_nx = ERR;
      end
      DECO: begin
        if (is_j)            st_nx = FETCH;
        else if (!op_ok)     st_nx = ERR;
        else                 st_nx = EXE;
      end
      EXE: begin
        if (is_r || is_addi)     st_nx = WB;
        else if (is_lw || is_sw) st_nx = MEM;
        else if (is_beq)         st_nx = FETCH;
        else                     st_nx = ERR;
      end
      MEM: begin
        if (bus.mem_ready)   st_nx = is_lw ? WB : FETCH;
        else if (timed_out)  st_nx = ERR;
      end
      WB:      st_nx = FETCH;
      default: st_nx = ERR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st       <= FETCH;
      wait_cnt <= '0;
      cnt      <= '0;
      err_q    <= 1'b0;
    end else begin
      st <= st_nx;
      if (st_nx != st)
        wait_cnt <= '0;
      else if ((st == FETCH || st == MEM) && !bus.mem_ready)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      if (retire)
        cnt <= cnt + CNT_W'(1);
      if (st_nx == ERR)
        err_q <= 1'b1;
    end
  end

  always_comb begin
    pc_ld_c     = 1'b0;
    ir_w_c      = 1'b0;
    reg_rd_c    = 1'b0;
    reg_wr_c    = 1'b0;
    mem_rd_c    = 1'b0;
    mem_wd_c    = 1'b0;
    sel_dir_c   = 1'b0;
    sel_dest_c  = 1'b0;
    sel_dat_c   = 1'b0;
    sel_operB_c = 1'b0;
    sel_pc_c    = 2'b00;
    sel_operA_c = 3'b000;
    alu_fun_c   = 3'b000;
    case (st)
      FETCH: begin
        mem_rd_c    = 1'b1;
        sel_operA_c = 3'b011;
        alu_fun_c   = ALU_ADD;
        if (bus.mem_ready) begin
          ir_w_c  = 1'b1;
          pc_ld_c = 1'b1;
        end
      end
      DECO: begin
        // PC+4 + imm<<2 is computed here so RegALU holds the branch target in EXE.
        reg_rd_c    = 1'b1;
        sel_operA_c = 3'b010;
        alu_fun_c   = ALU_ADD;
        if (is_j) begin
          pc_ld_c  = 1'b1;
          sel_pc_c = 2'b10;
        end
      end
      EXE: begin
        sel_operB_c = 1'b1;
        if (is_r) begin
          alu_fun_c = alu_r;
        end else if (is_beq) begin
          alu_fun_c = ALU_SUB;
          if (bus.zero) begin
            pc_ld_c  = 1'b1;
            sel_pc_c = 2'b01;
          end
        end else begin
          sel_operA_c = 3'b001;
          alu_fun_c   = ALU_ADD;
        end
      end
      MEM: begin
        sel_dir_c = 1'b1;
        mem_rd_c  = is_lw;
        mem_wd_c  = is_sw;
      end
      WB: begin
        reg_wr_c   = 1'b1;
        sel_dest_c = is_r;
        sel_dat_c  = is_lw;
      end
      default: ;
    endcase
  end

  // Strobes are gated by reset directly so they fall without waiting for a clock.
  assign bus.pc_ld       = pc_ld_c  & ~reset;
  assign bus.ir_w        = ir_w_c   & ~reset;
  assign bus.reg_rd      = reg_rd_c & ~reset;
  assign bus.reg_wr      = reg_wr_c & ~reset;
  assign bus.mem_rd      = mem_rd_c & ~reset;
  assign bus.mem_wd      = mem_wd_c & ~reset;
  assign bus.sel_dir     = sel_dir_c;
  assign bus.sel_dest    = sel_dest_c;
  assign bus.sel_dat     = sel_dat_c;
  assign bus.sel_operB   = sel_operB_c;
  assign bus.sel_pc      = sel_pc_c;
  assign bus.sel_operA   = sel_operA_c;
  assign bus.alu_fun     = alu_fun_c;
  assign bus.state       = st;
  assign bus.err         = err_q;
  assign bus.instr_count = cnt;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - directed bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;
  localparam int CW = 4;
  localparam int VW = 22 + CW;

  // field order: state, err, {pc_ld,ir_w,reg_rd,reg_wr,mem_rd,mem_wd},
  // {sel_dir,sel_dest,sel_dat,sel_operB}, sel_pc, sel_operA, alu_fun
  localparam logic [21:0] F_WAIT = {3'd0, 1'b0, 6'b000010, 4'b0000, 2'b00, 3'b011, 3'b010};
  localparam logic [21:0] F_GO   = {3'd0, 1'b0, 6'b110010, 4'b0000, 2'b00, 3'b011, 3'b010};
  localparam logic [21:0] D_NORM = {3'd1, 1'b0, 6'b001000, 4'b0000, 2'b00, 3'b010, 3'b010};
  localparam logic [21:0] D_J    = {3'd1, 1'b0, 6'b101000, 4'b0000, 2'b10, 3'b010, 3'b010};
  localparam logic [21:0] E_IMM  = {3'd2, 1'b0, 6'b000000, 4'b0001, 2'b00, 3'b001, 3'b010};
  localparam logic [21:0] E_BT   = {3'd2, 1'b0, 6'b100000, 4'b0001, 2'b01, 3'b000, 3'b110};
  localparam logic [21:0] E_BN   = {3'd2, 1'b0, 6'b000000, 4'b0001, 2'b00, 3'b000, 3'b110};
  localparam logic [21:0] M_LW   = {3'd3, 1'b0, 6'b000010, 4'b1000, 2'b00, 3'b000, 3'b000};
  localparam logic [21:0] M_SW   = {3'd3, 1'b0, 6'b000001, 4'b1000, 2'b00, 3'b000, 3'b000};
  localparam logic [21:0] W_R    = {3'd4, 1'b0, 6'b000100, 4'b0100, 2'b00, 3'b000, 3'b000};
  localparam logic [21:0] W_LW   = {3'd4, 1'b0, 6'b000100, 4'b0010, 2'b00, 3'b000, 3'b000};
  localparam logic [21:0] W_I    = {3'd4, 1'b0, 6'b000100, 4'b0000, 2'b00, 3'b000, 3'b000};
  localparam logic [21:0] S_ERR  = {3'd5, 1'b1, 6'b000000, 4'b0000, 2'b00, 3'b000, 3'b000};

  localparam logic [VW-1:0] MASK_ALL = '1;
  localparam logic [VW-1:0] MASK_RST = {{CW{1'b1}}, 3'b111, 1'b1, 6'b111111, 12'b0};

  typedef struct {
    string         tag;
    logic [VW-1:0] mask;
    logic [VW-1:0] exp;
  } sb_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] ecnt = '0;
  int            n_assert = 0;
  int            n_fail = 0;
  sb_t           sb_q[$];

  mips_multicycle_ctrl_if #(.CNT_W(CW)) bus ();

  mips_multicycle_ctrl #(.WAIT_W(4), .TIMEOUT(15), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [21:0] e_r(input logic [2:0] alu);
    return {3'd2, 1'b0, 6'b000000, 4'b0001, 2'b00, 3'b000, alu};
  endfunction

  function automatic logic [VW-1:0] observe();
    return {bus.instr_count, bus.state, bus.err, bus.pc_ld, bus.ir_w, bus.reg_rd,
            bus.reg_wr, bus.mem_rd, bus.mem_wd, bus.sel_dir, bus.sel_dest, bus.sel_dat,
            bus.sel_operB, bus.sel_pc, bus.sel_operA, bus.alu_fun};
  endfunction

  task automatic expect_now(input string tag, input logic [VW-1:0] mask, input logic [21:0] ev);
    sb_q.push_back('{tag, mask, {ecnt, ev}});
  endtask

  task automatic check_front();
    sb_t           e;
    logic [VW-1:0] obs;
    e   = sb_q.pop_front();
    obs = observe() & e.mask;
    n_assert++;
    assert (obs === (e.exp & e.mask))
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp & e.mask);
      end
  endtask

  // Called just after a rising edge; checks the cycle at the falling edge.
  task automatic cyc(input logic [5:0] opc, input logic [5:0] fn, input logic z,
                     input logic rdy, input logic [21:0] ev, input string tag,
                     input bit retire);
    bus.opcode    = opc;
    bus.funct     = fn;
    bus.zero      = z;
    bus.mem_ready = rdy;
    expect_now(tag, MASK_ALL, ev);
    @(negedge clk);
    check_front();
    @(posedge clk);
    #1;
    if (retire) ecnt = ecnt + 1'b1;
  endtask

  task automatic do_reset(input string tag);
    bus.mem_ready = 1'b1;
    #1 reset = 1'b1;
    ecnt = '0;
    #1;
    expect_now(tag, MASK_RST, 22'd0);
    check_front();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic r_type(input logic [5:0] fn, input logic [2:0] alu, input string tag);
    cyc(6'h00, fn, 1'b0, 1'b1, F_GO,     {tag, "_fetch"}, 0);
    cyc(6'h00, fn, 1'b0, 1'b1, D_NORM,   {tag, "_deco"},  0);
    cyc(6'h00, fn, 1'b0, 1'b1, e_r(alu), {tag, "_exe"},   0);
    cyc(6'h00, fn, 1'b0, 1'b1, W_R,      {tag, "_wb"},    1);
  endtask

  initial begin
    bus.opcode    = 6'h00;
    bus.funct     = 6'h20;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    #2;
    expect_now("reset_state", MASK_RST, 22'd0);
    check_front();
    @(posedge clk);
    #1 reset = 1'b0;

    r_type(6'h20, 3'b010, "add");
    r_type(6'h22, 3'b110, "sub");
    r_type(6'h24, 3'b000, "and");
    r_type(6'h25, 3'b001, "or");
    r_type(6'h2A, 3'b111, "slt");

    cyc(6'h08, 6'h00, 1'b0, 1'b1, F_GO,   "addi_fetch", 0);
    cyc(6'h08, 6'h00, 1'b0, 1'b1, D_NORM, "addi_deco",  0);
    cyc(6'h08, 6'h00, 1'b0, 1'b1, E_IMM,  "addi_exe",   0);
    cyc(6'h08, 6'h00, 1'b0, 1'b1, W_I,    "addi_wb",    1);

    cyc(6'h2B, 6'h00, 1'b0, 1'b1, F_GO,   "sw_fetch", 0);
    cyc(6'h2B, 6'h00, 1'b0, 1'b1, D_NORM, "sw_deco",  0);
    cyc(6'h2B, 6'h00, 1'b0, 1'b1, E_IMM,  "sw_exe",   0);
    cyc(6'h2B, 6'h00, 1'b0, 1'b1, M_SW,   "sw_mem",   1);

    cyc(6'h23, 6'h00, 1'b0, 1'b1, F_GO,   "lw_fetch", 0);
    cyc(6'h23, 6'h00, 1'b0, 1'b1, D_NORM, "lw_deco",  0);
    cyc(6'h23, 6'h00, 1'b0, 1'b1, E_IMM,  "lw_exe",   0);
    for (int i = 0; i < 3; i++)
      cyc(6'h23, 6'h00, 1'b0, 1'b0, M_LW, "lw_mem_wait", 0);
    cyc(6'h23, 6'h00, 1'b0, 1'b1, M_LW,   "lw_mem_done", 0);
    cyc(6'h23, 6'h00, 1'b0, 1'b1, W_LW,   "lw_wb",       1);

    cyc(6'h04, 6'h00, 1'b1, 1'b1, F_GO,   "beq_t_fetch", 0);
    cyc(6'h04, 6'h00, 1'b1, 1'b1, D_NORM, "beq_t_deco",  0);
    cyc(6'h04, 6'h00, 1'b1, 1'b1, E_BT,   "beq_t_exe",   1);
    cyc(6'h04, 6'h00, 1'b0, 1'b1, F_GO,   "beq_n_fetch", 0);
    cyc(6'h04, 6'h00, 1'b0, 1'b1, D_NORM, "beq_n_deco",  0);
    cyc(6'h04, 6'h00, 1'b0, 1'b1, E_BN,   "beq_n_exe",   1);

    cyc(6'h02, 6'h00, 1'b0, 1'b1, F_GO, "j_fetch", 0);
    cyc(6'h02, 6'h00, 1'b0, 1'b1, D_J,  "j_deco",  1);

    // fetch waits then a store that sits at the timeout limit and is rescued by ready
    for (int i = 0; i < 5; i++)
      cyc(6'h2B, 6'h00, 1'b0, 1'b0, F_WAIT, "sw2_fetch_wait", 0);
    cyc(6'h2B, 6'h00, 1'b0, 1'b1, F_GO,   "sw2_fetch", 0);
    cyc(6'h2B, 6'h00, 1'b0, 1'b1, D_NORM, "sw2_deco",  0);
    cyc(6'h2B, 6'h00, 1'b0, 1'b1, E_IMM,  "sw2_exe",   0);
    for (int i = 0; i < 15; i++)
      cyc(6'h2B, 6'h00, 1'b0, 1'b0, M_SW, "sw2_mem_wait", 0);
    cyc(6'h2B, 6'h00, 1'b0, 1'b1, M_SW,   "sw2_mem_ready_at_limit", 1);

    for (int i = 0; i < 15; i++)
      cyc(6'h02, 6'h00, 1'b0, 1'b0, F_WAIT, "fetch_wait15", 0);
    cyc(6'h02, 6'h00, 1'b0, 1'b1, F_GO, "fetch_ready_16th", 0);
    cyc(6'h02, 6'h00, 1'b0, 1'b1, D_J,  "fetch_16th_deco",  1);

    // enough jumps to carry instr_count through its wrap
    for (int i = 0; i < 5; i++) begin
      cyc(6'h02, 6'h00, 1'b0, 1'b1, F_GO, "wrap_j_fetch", 0);
      cyc(6'h02, 6'h00, 1'b0, 1'b1, D_J,  "wrap_j_deco",  1);
    end

    cyc(6'h3F, 6'h00, 1'b0, 1'b1, F_GO,   "badop_fetch", 0);
    cyc(6'h3F, 6'h00, 1'b0, 1'b1, D_NORM, "badop_deco",  0);
    for (int i = 0; i < 20; i++)
      cyc(6'($urandom_range(0, 63)), 6'h20, 1'($urandom_range(0, 1)), 1'(i % 2),
          S_ERR, "badop_err_sticky", 0);
    do_reset("badop_reset");
    cyc(6'h02, 6'h00, 1'b0, 1'b1, F_GO, "after_reset_fetch", 0);
    cyc(6'h02, 6'h00, 1'b0, 1'b1, D_J,  "after_reset_deco",  1);

    cyc(6'h00, 6'h03, 1'b0, 1'b1, F_GO,   "badfn_fetch", 0);
    cyc(6'h00, 6'h03, 1'b0, 1'b1, D_NORM, "badfn_deco",  0);
    for (int i = 0; i < 3; i++)
      cyc(6'h00, 6'h03, 1'b0, 1'b1, S_ERR, "badfn_err", 0);
    do_reset("badfn_reset");

    for (int i = 0; i < 16; i++)
      cyc(6'h23, 6'h00, 1'b0, 1'b0, F_WAIT, "timeout_fetch_wait", 0);
    cyc(6'h23, 6'h00, 1'b0, 1'b0, S_ERR, "timeout_err", 0);
    do_reset("timeout_reset");

    cyc(6'h23, 6'h00, 1'b0, 1'b1, F_GO,   "abort_fetch", 0);
    cyc(6'h23, 6'h00, 1'b0, 1'b1, D_NORM, "abort_deco",  0);
    cyc(6'h23, 6'h00, 1'b0, 1'b1, E_IMM,  "abort_exe",   0);
    cyc(6'h23, 6'h00, 1'b0, 1'b0, M_LW,   "abort_mem",   0);
    do_reset("abort_mid_mem");
    r_type(6'h20, 3'b010, "restart_add");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
